// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM states, pending-redirect source
// and the instruction-alignment mask.
package pc_gen_pkg;

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} pc_state_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_TRAP} redir_src_t;

  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_redirect_hold.sv
// Pending-redirect register: holds one redirect captured while the PC cannot advance.
// A trap beats a branch, and a newer branch replaces an older branch.
module pc_redirect_hold
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_addr,
  input  logic            apply,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_addr
);

  redir_src_t src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src       <= SRC_NONE;
      pend_addr <= '0;
    end else if (apply) begin
      // Any advancing edge consumes or discards the held redirect.
      src <= SRC_NONE;
    end else if (capture) begin
      if (trap_valid) begin
        src       <= SRC_TRAP;
        pend_addr <= trap_addr;
      end else if (br_valid && (src != SRC_TRAP)) begin
        src       <= SRC_BRANCH;
        pend_addr <= br_addr;
      end
    end
  end

  assign pend_valid = (src != SRC_NONE);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator feeding the instruction fetcher: sequential advance, stall hold,
// halt/resume and branch/trap redirects. Optional macro PC_MISALIGN_CHK_EN drops misaligned branches.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INCR  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            redir_valid_i,
  input  logic [XLEN-1:0] redir_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_en_o,
  output logic            pend_o,
  output logic            halted_o
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
`endif
);

  pc_state_t       state;
  logic [XLEN-1:0] br_addr;
  logic [XLEN-1:0] tr_addr;
  logic [XLEN-1:0] pend_addr;
  logic            br_valid;
  logic            pend_valid;

  assign br_addr = {redir_target_i[XLEN-1:2], redir_target_i[1:0] & ~PC_ALIGN_MASK};
  assign tr_addr = {trap_vec_i[XLEN-1:2], trap_vec_i[1:0] & ~PC_ALIGN_MASK};

`ifdef PC_MISALIGN_CHK_EN
  logic br_misaligned;

  assign br_misaligned = |(redir_target_i[1:0] & PC_ALIGN_MASK);
  assign br_valid      = redir_valid_i && !br_misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= redir_valid_i && br_misaligned;
      if (redir_valid_i && br_misaligned) misalign_addr_o <= redir_target_i;
    end
  end
`else
  assign br_valid = redir_valid_i;
`endif

  assign pc_en_o = (state == RUN) && !stall_i && !halt_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o <= RESET_PC;
    end else if (pc_en_o) begin
      if (trap_valid_i)    pc_o <= tr_addr;
      else if (br_valid)   pc_o <= br_addr;
      else if (pend_valid) pc_o <= pend_addr;
      else                 pc_o <= pc_o + XLEN'(PC_INCR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      halted_o <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN, STALL: begin
          if (halt_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end else begin
            state <= stall_i ? STALL : RUN;
          end
        end
        HALT: begin
          if (resume_i && !halt_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

  pc_redirect_hold #(
    .XLEN(XLEN)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .capture   (!pc_en_o),
    .trap_valid(trap_valid_i),
    .trap_addr (tr_addr),
    .br_valid  (br_valid),
    .br_addr   (br_addr),
    .apply     (pc_en_o),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr)
  );

  assign pend_o = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a
// behavioural model of the fetch-address rules.
`timescale 1ns/1ps
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, halt_i = 1'b0, resume_i = 1'b0;
  logic        redir_valid_i = 1'b0, trap_valid_i = 1'b0;
  logic [31:0] redir_target_i = '0, trap_vec_i = '0;
  logic [31:0] pc_o;
  logic        pc_en_o, pend_o, halted_o;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .PC_INCR (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .redir_valid_i (redir_valid_i),
    .redir_target_i(redir_target_i),
    .trap_valid_i  (trap_valid_i),
    .trap_vec_i    (trap_vec_i),
    .pc_o          (pc_o),
    .pc_en_o       (pc_en_o),
    .pend_o        (pend_o),
    .halted_o      (halted_o)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign_o     (misalign_o),
    .misalign_addr_o(misalign_addr_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode is one of the four named operating modes.
  localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_pend, m_pend_trap;
  logic [31:0] m_pend_addr;
  bit          m_mis;
  logic [31:0] m_mis_addr;
  bit          obs_en, exp_en;

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 32'h0; m_pend = 0; m_pend_trap = 0;
    m_pend_addr = 32'h0; m_mis = 0; m_mis_addr = 32'h0;
  endtask

  // Drive one cycle of inputs after the falling edge, sample pc_en_o, advance the model,
  // and return 1ns after the following rising edge.
  task automatic step(input bit st, input bit hl, input bit rs, input bit rv,
                      input logic [31:0] rt, input bit tv, input logic [31:0] tvec);
    logic [31:0] b_addr, t_addr;
    bit b_ok;
    @(negedge clk);
    stall_i = st; halt_i = hl; resume_i = rs;
    redir_valid_i = rv; redir_target_i = rt; trap_valid_i = tv; trap_vec_i = tvec;
    #1;
    obs_en = pc_en_o;
    exp_en = (m_mode == M_RUN) && !st && !hl;
    b_addr = rt & 32'hFFFF_FFFC;
    t_addr = tvec & 32'hFFFF_FFFC;
    b_ok = rv;
`ifdef PC_MISALIGN_CHK_EN
    b_ok  = rv && (rt % 4 == 0);
    m_mis = rv && (rt % 4 != 0);
    if (m_mis) m_mis_addr = rt;
`endif
    if (exp_en) begin
      if (tv)          m_pc = t_addr;
      else if (b_ok)   m_pc = b_addr;
      else if (m_pend) m_pc = m_pend_addr;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else if (tv) begin
      m_pend = 1; m_pend_trap = 1; m_pend_addr = t_addr;
    end else if (b_ok && !(m_pend && m_pend_trap)) begin
      m_pend = 1; m_pend_trap = 0; m_pend_addr = b_addr;
    end
    if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (m_mode == M_HALT) begin
      if (rs && !hl) m_mode = M_RUN;
    end else if (hl) m_mode = M_HALT;
    else m_mode = st ? M_STALL : M_RUN;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // Assert reset between edges, release it 1ns after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    stall_i = 0; halt_i = 0; resume_i = 0; redir_valid_i = 0; trap_valid_i = 0;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (pc_o !== 32'h0 || pc_en_o !== 1'b0 || pend_o !== 1'b0 || halted_o !== 1'b0) begin
      failures++; $display("FAIL reset_vals pc=%h en=%b pend=%b halt=%b exp 0/0/0/0", pc_o, pc_en_o, pend_o, halted_o);
    end
    do_reset();
    idle();
    checks++; if (obs_en !== 1'b0 || pc_o !== 32'h0) begin
      failures++; $display("FAIL boot_cycle en=%b pc=%h exp en=0 pc=0", obs_en, pc_o);
    end
    idle();
    checks++; if (obs_en !== 1'b1 || pc_o !== 32'h4) begin
      failures++; $display("FAIL first_adv en=%b pc=%h exp en=1 pc=4", obs_en, pc_o);
    end
    idle();
    idle();
    checks++; if (pc_o !== 32'hC) begin
      failures++; $display("FAIL seq_c pc=%h exp c", pc_o);
    end
    step(1, 0, 0, 1, 32'h700, 0, 32'h0);
    checks++; if (pend_o !== 1'b1) begin
      failures++; $display("FAIL pend_pre_rst pend=%b exp 1", pend_o);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h0 || pend_o !== 1'b0 || pc_en_o !== 1'b0) begin
      failures++; $display("FAIL async_rst pc=%h pend=%b en=%b exp 0/0/0", pc_o, pend_o, pc_en_o);
    end
    do_reset();
  endtask

  task automatic test_boot_redirect();
    do_reset();
    step(0, 0, 0, 1, 32'h500, 0, 32'h0);
    checks++; if (pc_o !== 32'h0 || pend_o !== 1'b1) begin
      failures++; $display("FAIL boot_redir pc=%h pend=%b exp 0/1", pc_o, pend_o);
    end
    idle();
    checks++; if (pc_o !== 32'h500 || pend_o !== 1'b0) begin
      failures++; $display("FAIL boot_apply pc=%h pend=%b exp 500/0", pc_o, pend_o);
    end
  endtask

  task automatic test_redirect();
    step(0, 0, 0, 1, 32'h10, 0, 32'h0);
    step(0, 0, 0, 1, 32'h100, 0, 32'h0);
    checks++; if (pc_o !== 32'h100) begin
      failures++; $display("FAIL redir pc=%h exp 100", pc_o);
    end
    idle();
    checks++; if (pc_o !== 32'h104) begin
      failures++; $display("FAIL redir_seq pc=%h exp 104", pc_o);
    end
  endtask

  task automatic test_stall_capture();
    step(0, 0, 0, 1, 32'h20, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h200, 0, 32'h0);
    checks++; if (pc_o !== 32'h20 || pend_o !== 1'b1 || obs_en !== 1'b0) begin
      failures++; $display("FAIL stall_cap pc=%h pend=%b en=%b exp 20/1/0", pc_o, pend_o, obs_en);
    end
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle();
    checks++; if (pc_o !== 32'h20) begin
      failures++; $display("FAIL stall_hold pc=%h exp 20", pc_o);
    end
    idle();
    checks++; if (pc_o !== 32'h200 || pend_o !== 1'b0) begin
      failures++; $display("FAIL stall_apply pc=%h pend=%b exp 200/0", pc_o, pend_o);
    end
    step(1, 0, 0, 1, 32'h240, 0, 32'h0);
    step(1, 0, 0, 1, 32'h280, 0, 32'h0);
    idle();
    idle();
    checks++; if (pc_o !== 32'h280) begin
      failures++; $display("FAIL br_overwrite pc=%h exp 280", pc_o);
    end
  endtask

  task automatic test_priority();
    step(0, 0, 0, 1, 32'h60, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 1, 32'h80);
    step(1, 0, 0, 1, 32'h300, 0, 32'h0);
    idle();
    idle();
    checks++; if (pc_o !== 32'h80) begin
      failures++; $display("FAIL trap_keep pc=%h exp 80", pc_o);
    end
    step(1, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h200, 0, 32'h0);
    idle();
    step(0, 0, 0, 1, 32'h400, 0, 32'h0);
    checks++; if (obs_en !== 1'b1 || pc_o !== 32'h400 || pend_o !== 1'b0) begin
      failures++; $display("FAIL release_live en=%b pc=%h pend=%b exp 1/400/0", obs_en, pc_o, pend_o);
    end
    idle();
    checks++; if (pc_o !== 32'h404) begin
      failures++; $display("FAIL release_disc pc=%h exp 404", pc_o);
    end
    step(0, 0, 0, 1, 32'h900, 1, 32'hA00);
    checks++; if (pc_o !== 32'hA00) begin
      failures++; $display("FAIL trap_over_br pc=%h exp a00", pc_o);
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    idle();
    checks++; if (pc_o !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap pc=%h exp 00000000", pc_o);
    end
  endtask

  task automatic test_halt();
    step(0, 0, 0, 1, 32'h40, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (obs_en !== 1'b0 || pc_o !== 32'h40 || halted_o !== 1'b1) begin
      failures++; $display("FAIL halt_enter en=%b pc=%h halted=%b exp 0/40/1", obs_en, pc_o, halted_o);
    end
    idle();
    step(0, 1, 1, 0, 32'h0, 0, 32'h0);
    checks++; if (halted_o !== 1'b1 || pc_o !== 32'h40) begin
      failures++; $display("FAIL halt_wins halted=%b pc=%h exp 1/40", halted_o, pc_o);
    end
    step(0, 0, 1, 0, 32'h0, 0, 32'h0);
    checks++; if (halted_o !== 1'b0 || pc_o !== 32'h40) begin
      failures++; $display("FAIL resume halted=%b pc=%h exp 0/40", halted_o, pc_o);
    end
    idle();
    checks++; if (pc_o !== 32'h44) begin
      failures++; $display("FAIL resume_adv pc=%h exp 44", pc_o);
    end
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h90);
    checks++; if (pend_o !== 1'b1 || pc_o !== 32'h44) begin
      failures++; $display("FAIL halt_trap pend=%b pc=%h exp 1/44", pend_o, pc_o);
    end
    step(0, 0, 1, 0, 32'h0, 0, 32'h0);
    idle();
    checks++; if (pc_o !== 32'h90 || pend_o !== 1'b0) begin
      failures++; $display("FAIL halt_trap_apply pc=%h pend=%b exp 90/0", pc_o, pend_o);
    end
  endtask

  task automatic test_align();
    step(0, 0, 0, 1, 32'h20, 0, 32'h0);
    step(0, 0, 0, 1, 32'h102, 0, 32'h0);
`ifdef PC_MISALIGN_CHK_EN
    checks++; if (pc_o !== 32'h24 || misalign_o !== 1'b1 || misalign_addr_o !== 32'h102) begin
      failures++; $display("FAIL misalign_drop pc=%h mis=%b addr=%h exp 24/1/102", pc_o, misalign_o, misalign_addr_o);
    end
    idle();
    checks++; if (pc_o !== 32'h28 || misalign_o !== 1'b0 || misalign_addr_o !== 32'h102 || pend_o !== 1'b0) begin
      failures++; $display("FAIL misalign_pulse pc=%h mis=%b addr=%h pend=%b exp 28/0/102/0", pc_o, misalign_o, misalign_addr_o, pend_o);
    end
`else
    checks++; if (pc_o !== 32'h100) begin
      failures++; $display("FAIL align_br pc=%h exp 100", pc_o);
    end
`endif
    step(0, 0, 0, 0, 32'h0, 1, 32'h83);
    checks++; if (pc_o !== 32'h80) begin
      failures++; $display("FAIL align_trap pc=%h exp 80", pc_o);
    end
  endtask

  task automatic test_random();
    bit st, hl, rs, rv, tv;
    logic [31:0] rt, tvec;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 30);
      hl = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 20);
      tv = ($urandom_range(0, 99) < 8);
      rt = $urandom;
      if ($urandom_range(0, 99) < 70) rt = rt & 32'hFFFF_FFFC;
      tvec = $urandom;
      step(st, hl, rs, rv, rt, tv, tvec);
      checks++; if (obs_en !== exp_en) begin
        failures++; $display("FAIL rnd_en cyc=%0d en=%b exp %b", i, obs_en, exp_en);
      end
      checks++; if (pc_o !== m_pc) begin
        failures++; $display("FAIL rnd_pc cyc=%0d pc=%h exp %h", i, pc_o, m_pc);
      end
      checks++; if (pend_o !== m_pend || halted_o !== (m_mode == M_HALT)) begin
        failures++; $display("FAIL rnd_flags cyc=%0d pend=%b halted=%b exp %b/%b", i, pend_o, halted_o, m_pend, m_mode == M_HALT);
      end
`ifdef PC_MISALIGN_CHK_EN
      checks++; if (misalign_o !== m_mis || misalign_addr_o !== m_mis_addr) begin
        failures++; $display("FAIL rnd_mis cyc=%0d mis=%b addr=%h exp %b/%h", i, misalign_o, misalign_addr_o, m_mis, m_mis_addr);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_boot_redirect();
    test_redirect();
    test_stall_capture();
    test_priority();
    test_wrap();
    test_halt();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Program-counter generator sitting directly upstream of the instruction fetcher. It drives the fetch address and the pc-enable qualifier into the fetcher, and holds the address while the fetcher signals stall. It also accepts branch/jump redirects and trap redirects from later stages; a redirect that arrives during a stall is captured and applied once the stall releases.

Parameters:
XLEN, 32, address width
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_INCR, 4, sequential increment in bytes

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stall_i  in  1  fetcher stall; hold pc_o while high
halt_i  in  1  enter HALT (e.g. ecall/ebreak from later stage)
resume_i  in  1  leave HALT
redir_valid_i  in  1  branch/jump taken, one-cycle pulse
redir_target_i  in  XLEN  branch/jump target
trap_valid_i  in  1  trap taken, one-cycle pulse
trap_vec_i  in  XLEN  trap vector address
pc_o  out  XLEN  fetch address to fetcher ADDR_IN
pc_en_o  out  1  high when pc_o is a live fetch address that advances at the next edge
pend_o  out  1  a redirect is held pending
halted_o  out  1  state is HALT

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_o=RESET_PC; pc_en_o=0; pend_o=0; halted_o=0; state=BOOT; pending register cleared.
- States are BOOT, RUN, STALL, HALT.
  - BOOT: lasts exactly one cycle after rst deasserts, then goes to RUN. pc_o stays RESET_PC, so RESET_PC is the first address fetched.
  - RUN to STALL: when stall_i=1.
  - STALL to RUN: when stall_i=0.
  - RUN or STALL to HALT: when halt_i=1.
  - HALT to RUN: when resume_i=1. If halt_i and resume_i are high together, halt_i wins.
- pc_en_o is combinational: (state==RUN) && !stall_i && !halt_i.
- Next-PC selection at each edge when pc_en_o=1, in priority order:
  1. trap_valid_i: next pc = trap_vec_i
  2. redir_valid_i: next pc = redir_target_i
  3. pending valid: next pc = pending address; pending clears
  4. otherwise: next pc = pc_o + PC_INCR
- Latency: a redirect presented in cycle N appears on pc_o in cycle N+1.
- Sequential add is modulo 2^XLEN: 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no flag.
- Capture when pc_en_o=0 (STALL, HALT, or a stall_i cycle):
  - trap_valid_i or redir_valid_i writes the pending register; pend_o goes high the next cycle.
  - Trap overwrites a pending redirect.
  - A branch redirect does not overwrite a pending trap.
  - A later branch redirect overwrites an earlier pending branch redirect.
  - pc_o holds.
- Stall release in the same cycle as a new redirect: the live redirect wins; pending is discarded.
- HALT: pending is retained. A trap arriving during HALT is captured; on resume it is applied at the first pc_en_o edge.
- A redirect during BOOT is captured as pending. pc_o still shows RESET_PC for the first fetch, and the pending address is applied at the first RUN advance.
- Reset mid-operation drops pending and restarts from BOOT.
- redir_target_i[1:0] and trap_vec_i[1:0] are forced to 2'b00 before selection; see the optional feature for the exception.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - Adds misalign_o (out, 1) and misalign_addr_o (out, XLEN).
  - A redirect target with bits[1:0]!=0 is dropped. It is not applied and not made pending.
  - misalign_o pulses high for one cycle in the cycle after the drop, and misalign_addr_o holds the offending target until the next misalignment.
  - Reset values: misalign_o=0, misalign_addr_o=0.
  - Trap vectors are not checked.
- Undefined: the ports are absent and the low two bits are forced to zero.

Decomposition:
- Package pc_gen_pkg:
  - pc_state_t enum {BOOT, RUN, STALL, HALT}
  - redir_src_t enum {SRC_NONE, SRC_BRANCH, SRC_TRAP} for the pending source
  - constant PC_ALIGN_MASK
- Sub-module pc_redirect_hold: pending register with source-priority overwrite and clear-on-apply. Inputs: capture enable, trap/branch valid+address, apply. Outputs: pend_valid, pend_addr.

Test Plan:
- Reset release, stall_i=0 -> pc_o 0x0 for 2 cycles (reset+BOOT), then 0x4, 0x8, 0xC; pc_en_o rises the cycle after BOOT.
- RUN at pc_o=0x10, redir_valid_i=1 with target 0x100 -> pc_o=0x100 next cycle, then 0x104.
- stall_i high 3 cycles at pc_o=0x20; branch redirect 0x200 in the 2nd stall cycle -> pc_o holds 0x20 and pend_o=1; after release pc_o=0x200, pend_o=0.
- During a stall, trap 0x80 then branch 0x300 -> after release pc_o=0x80. Separately, a redirect in the release cycle to 0x400 with 0x200 pending -> pc_o=0x400.
- pc_o=0xFFFF_FFFC, no redirect -> pc_o=0x0000_0000.
- halt_i pulse at pc_o=0x40 -> halted_o=1, pc_en_o=0, pc_o held; resume_i -> 0x44.
- With PC_MISALIGN_CHK_EN, redirect to 0x102 -> ignored, sequential PC continues, misalign_o pulses once, misalign_addr_o=0x102.
